// File: rtl/nsub32_clk.sv
// nsub32_clk: clocked 32-bit subtractor, d = a - b - bi.
// One SLICE-bit carry-lookahead slice is evaluated per clock, LSB first. The
// borrow between slices is kept in a register, so a full operation takes
// NSLICE clocks after the start is accepted.
//
// Optional feature macro: NSUB_ADD_MODE_EN. When it is defined, an extra input
// 'op' selects addition (op=1). With op=0 the block subtracts as usual.
//
// Ports:
//   clk    rising-edge clock
//   reset  synchronous, active-high reset
//   start  request pulse, sampled only when busy=0
//   a, b   operands, captured on the accepted start
//   bi     borrow in (carry in when adding), captured on the accepted start
//   op     (NSUB_ADD_MODE_EN only) 1 = add, 0 = subtract
//   busy   high while the slices are being processed
//   done   one-cycle pulse when d/bo/ov are valid
//   d      result, held until the next operation overwrites it
//   bo     borrow out (carry out when adding)
//   ov     signed overflow
module nsub32_clk #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned SLICE = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bi,
`ifdef NSUB_ADD_MODE_EN
    input  logic             op,
`endif
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] d,
    output logic             bo,
    output logic             ov
);

    localparam int unsigned NSLICE = WIDTH / SLICE;
    localparam int unsigned KW     = (NSLICE > 1) ? $clog2(NSLICE) : 1;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] a_r;
    logic [WIDTH-1:0] b_r;
    logic             cb;       // borrow (subtract) or carry (add) into slice k
    logic [KW-1:0]    k;
`ifdef NSUB_ADD_MODE_EN
    logic             op_r;
`endif

    logic [SLICE-1:0] sa;
    logic [SLICE-1:0] sb;
    logic [SLICE-1:0] sp;
    logic [SLICE-1:0] sg;
    logic [SLICE-1:0] ssum;
    logic [SLICE:0]   cy;
    logic             cin;
    logic             pp;
    logic             cb_next;
    logic             ov_next;

    // Slice datapath. Subtraction is a + ~b + ~borrow; the carry of every bit
    // is formed in lookahead style from generate/propagate terms.
    always_comb begin
        sa  = a_r[k*SLICE +: SLICE];
        sb  = ~b_r[k*SLICE +: SLICE];
        cin = ~cb;
`ifdef NSUB_ADD_MODE_EN
        if (op_r) begin
            sb  = b_r[k*SLICE +: SLICE];
            cin = cb;
        end
`endif
        sp    = sa ^ sb;
        sg    = sa & sb;
        cy    = '0;
        cy[0] = cin;
        pp    = 1'b0;
        for (int unsigned i = 0; i < SLICE; i++) begin
            // c[i+1] = g[i] | p[i]g[i-1] | ... | p[i..0]cin
            pp        = sp[i];
            cy[i + 1] = sg[i];
            for (int unsigned j = 0; j < i; j++) begin
                cy[i + 1] = cy[i + 1] | (pp & sg[i - 1 - j]);
                pp        = pp & sp[i - 1 - j];
            end
            cy[i + 1] = cy[i + 1] | (pp & cin);
        end
        ssum    = sp ^ cy[SLICE-1:0];
        cb_next = ~cy[SLICE];
        ov_next = (a_r[WIDTH-1] != b_r[WIDTH-1]) && (ssum[SLICE-1] != a_r[WIDTH-1]);
`ifdef NSUB_ADD_MODE_EN
        if (op_r) begin
            cb_next = cy[SLICE];
            ov_next = (a_r[WIDTH-1] == b_r[WIDTH-1]) && (ssum[SLICE-1] != a_r[WIDTH-1]);
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
            d     <= '0;
            bo    <= 1'b0;
            ov    <= 1'b0;
            a_r   <= '0;
            b_r   <= '0;
            cb    <= 1'b0;
            k     <= '0;
`ifdef NSUB_ADD_MODE_EN
            op_r  <= 1'b0;
`endif
        end else begin
            case (state)
                RUN: begin
                    d[k*SLICE +: SLICE] <= ssum;
                    cb                  <= cb_next;
                    k                   <= k + 1'b1;
                    if (k == KW'(NSLICE - 1)) begin
                        bo    <= cb_next;
                        ov    <= ov_next;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= DONE;
                    end
                end
                default: begin
                    // IDLE and DONE accept a new request the same way, which
                    // gives back-to-back operation out of DONE.
                    done <= 1'b0;
                    if (start) begin
                        a_r   <= a;
                        b_r   <= b;
                        cb    <= bi;
                        k     <= '0;
`ifdef NSUB_ADD_MODE_EN
                        op_r  <= op;
`endif
                        busy  <= 1'b1;
                        state <= RUN;
                    end else begin
                        state <= IDLE;
                    end
                end
            endcase
        end
    end

endmodule
